// File: rtl/vram_arbiter_if.sv
// MIG user-port command/write-data bundle plus the BO FIFO beat handshake.
// master = arbiter side, slave = MIG wrapper / FIFO side.
interface vram_arbiter_if;
    logic        wr_src_valid;
    logic        wr_src_ready;
    logic        mig_wr_en;
    logic        mig_wr_full;
    logic        mig_cmd_en;
    logic [2:0]  mig_cmd_instr;
    logic [5:0]  mig_cmd_bl;
    logic [29:0] mig_cmd_byte_addr;
    logic        mig_cmd_full;

    modport master (
        input  wr_src_valid, mig_wr_full, mig_cmd_full,
        output wr_src_ready, mig_wr_en, mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr
    );

    modport slave (
        output wr_src_valid, mig_wr_full, mig_cmd_full,
        input  wr_src_ready, mig_wr_en, mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr
    );
endinterface

// File: rtl/vram_arbiter.sv
// Round-robin read/write burst scheduler on the MIG port; first cmd 2 cycles after vsync, stalls on FIFO full flags.
// Define VRAM_ARB_WR_PRIO_EN for fixed write-over-read priority instead of round-robin.
module vram_arbiter #(
    parameter int          BURST_BEATS = 8,
    parameter logic [29:0] RD_BASE     = 30'h0000000,
    parameter logic [29:0] WR_BASE     = 30'h0000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  vsync,
    input  logic [23:0]           frame_bytes,
    input  logic                  rd_room,
    vram_arbiter_if.master        mif,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error
);
    localparam int BB  = BURST_BEATS * 16;
    localparam int LG  = $clog2(BB);
    localparam int CW  = 24 - LG;
    localparam int BCW = $clog2(BURST_BEATS) + 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_RD_CMD, S_WR_FILL, S_WR_CMD, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  rd_left, wr_left;
    logic [29:0]    rd_addr, wr_addr;
    logic [BCW-1:0] beat_cnt;
    logic           last_grant_wr;

    logic           rd_elig, wr_elig, grant_rd, grant_wr;
    logic           cmd_en, src_ready, wr_beat;
    logic [2:0]     cmd_instr;
    logic [29:0]    cmd_addr;
    logic           frame_start;

    logic           unused_low_bytes;
    assign unused_low_bytes = ^frame_bytes[LG-1:0];

    assign rd_elig     = (rd_left != '0) && rd_room;
    assign wr_elig     = (wr_left != '0) && mif.wr_src_valid;
    assign frame_start = (state == S_IDLE) && vsync && enable;

`ifdef VRAM_ARB_WR_PRIO_EN
    assign grant_wr = wr_elig;
    assign grant_rd = rd_elig && !wr_elig;
`else
    // On a tie the stream that did not win last time goes next.
    assign grant_rd = rd_elig && (!wr_elig || last_grant_wr);
    assign grant_wr = wr_elig && (!rd_elig || !last_grant_wr);
`endif

    always_comb begin
        state_nxt = state;
        cmd_en    = 1'b0;
        cmd_instr = 3'b000;
        cmd_addr  = '0;
        src_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_ARB;
            end
            S_ARB: begin
                if (rd_left == '0 && wr_left == '0) state_nxt = S_DONE;
                else if (!enable)                   state_nxt = S_IDLE;
                else if (grant_rd)                  state_nxt = S_RD_CMD;
                else if (grant_wr)                  state_nxt = S_WR_FILL;
            end
            S_RD_CMD: begin
                cmd_en    = !mif.mig_cmd_full;
                cmd_instr = 3'b001;
                cmd_addr  = rd_addr;
                if (!mif.mig_cmd_full) state_nxt = S_ARB;
            end
            S_WR_FILL: begin
                src_ready = !mif.mig_wr_full;
                if (src_ready && mif.wr_src_valid && beat_cnt == LAST_BEAT) state_nxt = S_WR_CMD;
            end
            S_WR_CMD: begin
                cmd_en    = !mif.mig_cmd_full;
                cmd_addr  = wr_addr;
                if (!mif.mig_cmd_full) state_nxt = S_ARB;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wr_beat = src_ready && mif.wr_src_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rd_left       <= '0;
            wr_left       <= '0;
            rd_addr       <= RD_BASE;
            wr_addr       <= WR_BASE;
            beat_cnt      <= '0;
            last_grant_wr <= 1'b1;
            error         <= 1'b0;
        end else begin
            state <= state_nxt;
            // A trigger arriving mid-frame is flagged and otherwise dropped.
            if (vsync && state != S_IDLE) error <= 1'b1;
            if (frame_start) begin
                rd_left  <= frame_bytes[23:LG];
                wr_left  <= frame_bytes[23:LG];
                rd_addr  <= RD_BASE;
                wr_addr  <= WR_BASE;
                beat_cnt <= '0;
            end
            if (state == S_ARB && state_nxt == S_RD_CMD)  last_grant_wr <= 1'b0;
            if (state == S_ARB && state_nxt == S_WR_FILL) last_grant_wr <= 1'b1;
            if (cmd_en && state == S_RD_CMD) begin
                rd_left <= rd_left - CW'(1);
                rd_addr <= rd_addr + 30'(BB);
            end
            if (cmd_en && state == S_WR_CMD) begin
                wr_left <= wr_left - CW'(1);
                wr_addr <= wr_addr + 30'(BB);
            end
            if (wr_beat) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BCW'(1);
        end
    end

    assign mif.mig_cmd_en        = cmd_en;
    assign mif.mig_cmd_instr     = cmd_instr;
    assign mif.mig_cmd_byte_addr = cmd_addr;
    assign mif.mig_cmd_bl        = 6'(BURST_BEATS - 1);
    assign mif.wr_src_ready      = src_ready;
    assign mif.mig_wr_en         = wr_beat;
    assign busy                  = (state != S_IDLE);
    assign frame_done            = (state == S_DONE);
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed corner cases plus randomized frames against a per-stream address/order model.
module tb_vram_arbiter;
    localparam int          BEATS = 8;
    localparam int          BB    = BEATS * 16;
    localparam logic [29:0] RDB   = 30'h0000000;
    localparam logic [29:0] WRB   = 30'h3FFFFF00;

    logic        clk = 1'b0;
    logic        rst, enable, vsync, rd_room;
    logic [23:0] frame_bytes;
    logic        busy, frame_done, error;

    vram_arbiter_if mif();

    vram_arbiter #(.BURST_BEATS(BEATS), .RD_BASE(RDB), .WR_BASE(WRB)) dut (
        .clk(clk), .rst(rst), .enable(enable), .vsync(vsync), .frame_bytes(frame_bytes),
        .rd_room(rd_room), .mif(mif), .busy(busy), .frame_done(frame_done), .error(error)
    );

    always #5 clk = ~clk;

    int n_chk, n_fail;
    int cyc, vs_cyc, done_cnt, done_cyc, beats, drv_mode;
    logic [2:0]  cmd_instr_q[$];
    logic [29:0] cmd_addr_q[$];
    int          cmd_cyc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            beats = 0;
        end else begin
            if (vsync) vs_cyc = cyc;
            if (mif.mig_wr_en) begin
                check("wr_en_while_full", 32'(mif.mig_wr_full), 0);
                beats++;
            end
            if (mif.mig_cmd_en) begin
                check("push_while_cmd_full", 32'(mif.mig_cmd_full), 0);
                check("cmd_bl", 32'(mif.mig_cmd_bl), BEATS - 1);
                cmd_instr_q.push_back(mif.mig_cmd_instr);
                cmd_addr_q.push_back(mif.mig_cmd_byte_addr);
                cmd_cyc_q.push_back(cyc);
                if (mif.mig_cmd_instr == 3'b000) begin
                    check("beats_per_write", beats, BEATS);
                    beats = 0;
                end
            end
            if (frame_done) begin
                check("busy_during_done", 32'(busy), 1);
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (drv_mode == 1) begin
            rd_room          = ($urandom_range(0, 3) != 0);
            mif.wr_src_valid = ($urandom_range(0, 3) != 0);
            mif.mig_wr_full  = ($urandom_range(0, 4) == 0);
            mif.mig_cmd_full = ($urandom_range(0, 4) == 0);
        end else if (drv_mode == 2) begin
            mif.wr_src_valid = ~mif.wr_src_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
    endtask

    task automatic clear_log();
        cmd_instr_q.delete();
        cmd_addr_q.delete();
        cmd_cyc_q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != start) break;
            step();
        end
        check({tag, "_frame_done_seen"}, done_cnt - start, 1);
    endtask

    // Each stream must issue n bursts at consecutive BB-spaced addresses from its base.
    task automatic check_stream(input string tag, input logic [2:0] ins, input logic [29:0] base, input int n);
        int k;
        logic [29:0] a;
        k = 0;
        foreach (cmd_instr_q[i]) begin
            if (cmd_instr_q[i] == ins) begin
                a = base + 30'(k * BB);
                check({tag, "_addr"}, cmd_addr_q[i], a);
                k++;
            end
        end
        check({tag, "_count"}, k, n);
    endtask

    // Order expected when both streams are always eligible.
    function automatic logic [2:0] ideal_instr(input int i, input int n);
`ifdef VRAM_ARB_WR_PRIO_EN
        return (i < n) ? 3'b000 : 3'b001;
`else
        return (i % 2 == 0) ? 3'b001 : 3'b000;
`endif
    endfunction

    initial begin
        int nb;
        rst = 1'b1; enable = 1'b0; vsync = 1'b0; rd_room = 1'b0; frame_bytes = '0;
        mif.wr_src_valid = 1'b0; mif.mig_wr_full = 1'b0; mif.mig_cmd_full = 1'b0;
        drv_mode = 0;
        do_reset();

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_cmd_en", 32'(mif.mig_cmd_en), 0);
        check("rst_src_ready", 32'(mif.wr_src_ready), 0);
        check("rst_wr_en", 32'(mif.mig_wr_en), 0);
        check("rst_addr", 32'(mif.mig_cmd_byte_addr), 0);
        check("rst_instr", 32'(mif.mig_cmd_instr), 0);

        // Full-rate frame of 4 bursts each way
        clear_log();
        enable = 1'b1; rd_room = 1'b1; mif.wr_src_valid = 1'b1; frame_bytes = 24'd512;
        pulse_vsync();
        wait_done("basic", 200);
        check("basic_ncmd", cmd_instr_q.size(), 8);
        foreach (cmd_instr_q[i]) check("basic_order", 32'(cmd_instr_q[i]), 32'(ideal_instr(i, 4)));
        check_stream("basic_rd", 3'b001, RDB, 4);
        check_stream("basic_wr", 3'b000, WRB, 4);
        if (cmd_cyc_q.size() > 0) check("basic_first_cmd_latency", cmd_cyc_q[0] - vs_cyc, 2);
        check("basic_busy_after_done", 32'(busy), 0);
        check("basic_error", 32'(error), 0);
        repeat (5) step();
        check("basic_single_done", done_cnt, 1);

        // Command FIFO full for 5 cycles while the read command is pending
        clear_log();
        frame_bytes = 24'd128;
        mif.mig_cmd_full = 1'b1;
        pulse_vsync();
        repeat (6) step();
        mif.mig_cmd_full = 1'b0;
        wait_done("stall", 200);
        check("stall_ncmd", cmd_instr_q.size(), 2);
        check_stream("stall_rd", 3'b001, RDB, 1);
        check_stream("stall_wr", 3'b000, WRB, 1);
        if (cmd_cyc_q.size() > 0) check("stall_push_cycle", cmd_cyc_q[0] - vs_cyc, 7);

        // Toggling source valid and a write-FIFO-full pulse during fill
        clear_log();
        drv_mode = 2;
        pulse_vsync();
        repeat (5) step();
        mif.mig_wr_full = 1'b1;
        repeat (3) step();
        mif.mig_wr_full = 1'b0;
        wait_done("toggle", 300);
        drv_mode = 0;
        mif.wr_src_valid = 1'b1;
        check_stream("toggle_rd", 3'b001, RDB, 1);
        check_stream("toggle_wr", 3'b000, WRB, 1);

        // Frame shorter than one burst
        clear_log();
        frame_bytes = 24'd100;
        pulse_vsync();
        wait_done("zero", 10);
        check("zero_ncmd", cmd_instr_q.size(), 0);
        check("zero_done_latency", done_cyc - vs_cyc, 2);

        // Second vsync mid-frame
        clear_log();
        frame_bytes = 24'd512;
        pulse_vsync();
        repeat (5) step();
        pulse_vsync();
        step();
        check("err_set", 32'(error), 1);
        wait_done("err", 300);
        repeat (5) step();
        check("err_ncmd", cmd_instr_q.size(), 8);
        check_stream("err_rd", 3'b001, RDB, 4);
        check_stream("err_wr", 3'b000, WRB, 4);
        check("err_single_done", done_cnt, 1);
        check("err_sticky", 32'(error), 1);
        do_reset();
        check("err_cleared_by_rst", 32'(error), 0);

        // enable dropped mid write fill
        clear_log();
        rd_room = 1'b0;
        pulse_vsync();
        for (int i = 0; i < 20 && beats < 3; i++) step();
        check("drop_reached_3_beats", 32'(beats >= 3), 1);
        enable = 1'b0;
        repeat (30) step();
        check("drop_ncmd", cmd_instr_q.size(), 1);
        check_stream("drop_wr", 3'b000, WRB, 1);
        check("drop_no_done", done_cnt, 0);
        check("drop_busy", 32'(busy), 0);
        check("drop_no_extra_beats", beats, 0);

        // Reset while a read command is held back by cmd_full
        clear_log();
        enable = 1'b1; rd_room = 1'b1;
        mif.mig_cmd_full = 1'b1;
        pulse_vsync();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mif.mig_cmd_full = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_cmd_en", 32'(mif.mig_cmd_en), 0);
        check("rstmid_addr", 32'(mif.mig_cmd_byte_addr), 0);
        check("rstmid_instr", 32'(mif.mig_cmd_instr), 0);
        check("rstmid_src_ready", 32'(mif.wr_src_ready), 0);
        check("rstmid_frame_done", 32'(frame_done), 0);
        repeat (20) step();
        check("rstmid_idle_no_cmd", cmd_instr_q.size(), 0);

        // Randomized frames under random flow control
        drv_mode = 1;
        for (int f = 0; f < 6; f++) begin
            clear_log();
            nb = $urandom_range(0, 6);
            frame_bytes = 24'(nb * BB + $urandom_range(0, BB - 1));
            pulse_vsync();
            wait_done("rand", 3000);
            check_stream("rand_rd", 3'b001, RDB, nb);
            check_stream("rand_wr", 3'b000, WRB, nb);
            step();
        end
        drv_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Command-level scheduler that shares the single MIG user port between two streams. The read stream moves the previous frame from VRAM to the EPDC input FIFO. The write stream moves the new frame from the EPDC output FIFO back to VRAM. On each frame trigger it issues fixed-size read and write bursts until frame_bytes have been moved in each direction, arbitrating round-robin. It sits in the clk_mif domain between the BI/BO FIFOs and the MIG wrapper.

Parameters:
BURST_BEATS, 8, 128-bit beats per MIG burst; power of two, 1..64; burst bytes BB = BURST_BEATS*16.
RD_BASE, 30'h0000000, VRAM byte address of the frame read by the read stream.
WR_BASE, 30'h0000000, VRAM byte address of the frame written by the write stream.

Ports:
clk  in  1  MIG user clock
rst  in  1  synchronous active-high reset
enable  in  1  level; permits a new frame to start
vsync  in  1  one-cycle frame trigger, already synchronised to clk
frame_bytes  in  24  bytes per frame in each direction; bits below log2(BB) ignored
rd_room  in  1  downstream FIFO can absorb one full read burst
wr_src_valid  in  1  BO FIFO has a beat available
wr_src_ready  out  1  beat accepted into MIG write FIFO this cycle
mig_wr_en  out  1  = wr_src_valid && wr_src_ready
mig_wr_full  in  1  MIG write FIFO full
mig_cmd_en  out  1  command push strobe
mig_cmd_instr  out  3  3'b000 write, 3'b001 read
mig_cmd_bl  out  6  constant BURST_BEATS-1
mig_cmd_byte_addr  out  30  burst start address
mig_cmd_full  in  1  MIG command FIFO full
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse when both streams have completed
error  out  1  sticky; set by vsync while busy; cleared only by rst

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - rd_left and wr_left 0
  - last_grant = WRITE, so the first tie goes to READ
- Counters:
  - rd_left and wr_left are in bursts, width 24-log2(BB).
  - Both load frame_bytes>>log2(BB) on frame start.
  - rd_addr loads RD_BASE and wr_addr loads WR_BASE; each advances by BB after its own command is pushed.
  - Addresses use 30-bit modulo wrap.
- State machine: IDLE, ARB, RD_CMD, WR_FILL, WR_CMD, DONE.
  - IDLE:
    - vsync && enable -> load counters, go to ARB. A vsync at cycle N gives ARB at N+1, and the earliest mig_cmd_en is at N+2.
    - vsync while !enable is ignored.
  - ARB: an eligible request is granted.
    - rd_elig = rd_left!=0 && rd_room
    - wr_elig = wr_left!=0 && wr_src_valid
    - If both are eligible, grant the stream that is not last_grant. Update last_grant on grant.
    - READ -> RD_CMD; WRITE -> WR_FILL.
    - If rd_left==0 && wr_left==0 -> DONE.
    - If !enable -> IDLE, with no frame_done.
    - Otherwise stay in ARB.
  - RD_CMD:
    - mig_cmd_en = !mig_cmd_full; instr 001; addr rd_addr.
    - On push: rd_left-1, rd_addr+BB, -> ARB.
    - Holds while mig_cmd_full is high.
  - WR_FILL:
    - wr_src_ready = !mig_wr_full.
    - Beat counter counts accepted beats. After BURST_BEATS beats -> WR_CMD.
    - Stalls indefinitely on a starved source. Reads are blocked meanwhile; this is intended.
  - WR_CMD:
    - mig_cmd_en = !mig_cmd_full; instr 000; addr wr_addr.
    - On push: wr_left-1, wr_addr+BB, -> ARB.
  - DONE: frame_done=1 for one cycle, -> IDLE.
- mig_cmd_en, wr_src_ready and mig_wr_en are combinational from the state and FIFO flags. They are never asserted in IDLE, ARB or DONE. Exactly one push occurs per command.
- enable deasserted mid-burst: the current RD_CMD, WR_FILL or WR_CMD completes, then ARB returns to IDLE. No partial bursts are ever issued.
- frame_bytes < BB (zero bursts): IDLE -> ARB -> DONE; frame_done is asserted 2 cycles after vsync.
- vsync while busy: error set, vsync ignored, and the frame in progress continues unaffected.
- rst mid-operation: immediate return to reset values. Already-pushed MIG commands are not recalled.

Optional Feature:
VRAM_ARB_WR_PRIO_EN
- Defined: ARB uses fixed priority. Write wins whenever wr_elig, and read is granted only if !wr_elig. last_grant is still tracked but unused.
- Undefined: round-robin as described above.

Test Plan:
- BURST_BEATS=8, frame_bytes=24'd512 (4 bursts), rd_room=1, wr_src_valid=1, no full flags -> commands alternate R,W,R,W,R,W,R,W. Read addrs 0,128,256,384; write addrs WR_BASE+0..384; frame_done pulses once and busy falls the same cycle.
- mig_cmd_full held high 5 cycles during RD_CMD -> mig_cmd_en stays 0 for those cycles. Exactly one push occurs afterwards, and the address is not skipped.
- wr_src_valid toggling 1/0 each cycle in WR_FILL, mig_wr_full pulsed once -> exactly 8 mig_wr_en before write cmd; no mig_wr_en while mig_wr_full=1.
- frame_bytes=24'd100 -> no commands issued; frame_done 2 cycles after vsync. Second vsync during an active frame -> error=1 and remains set until rst.
- enable dropped during WR_FILL after 3 beats -> remaining 5 beats and the write cmd complete; then IDLE, no frame_done. rst asserted in RD_CMD -> next cycle all outputs 0, state IDLE.
- With VRAM_ARB_WR_PRIO_EN, rd_room=1, wr_src_valid=1 -> all 4 write bursts precede the first read command.
